// File: rtl/vip_frame_arbiter.sv
// Two-input Avalon-ST frame arbiter: an input owns the source for a whole frame (control packets + one video packet).
// Build macro VIP_ARB_FIXED_PRIORITY_EN selects fixed priority (input 0 wins ties) instead of round-robin.
module vip_frame_arbiter #(
    parameter int BITWIDTH  = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BITWIDTH-1:0]  sink0_data,
    input  logic                 sink0_valid,
    input  logic                 sink0_sop,
    input  logic                 sink0_eop,
    output logic                 sink0_ready,
    input  logic [BITWIDTH-1:0]  sink1_data,
    input  logic                 sink1_valid,
    input  logic                 sink1_sop,
    input  logic                 sink1_eop,
    output logic                 sink1_ready,
    output logic [BITWIDTH-1:0]  source_data,
    output logic                 source_valid,
    output logic                 source_sop,
    output logic                 source_eop,
    input  logic                 source_ready,
    output logic [1:0]           grant,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 proto_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state;
    logic               in_pkt;
    logic [3:0]         pkt_type;
`ifndef VIP_ARB_FIXED_PRIORITY_EN
    logic               last_grant;
`endif

    logic               req0;
    logic               req1;
    logic               drop0;
    logic               drop1;
    logic [1:0]         next_grant;
    logic               accept;
    logic               release_frame;
    logic [3:0]         eff_type;
    logic [1:0]         drop_inc;
    logic [CNT_WIDTH:0] drop_sum;

    assign req0  = sink0_valid & sink0_sop;
    assign req1  = sink1_valid & sink1_sop;
    assign drop0 = (state == IDLE) & sink0_valid & ~sink0_sop;
    assign drop1 = (state == IDLE) & sink1_valid & ~sink1_sop;

    always_comb begin
`ifdef VIP_ARB_FIXED_PRIORITY_EN
        next_grant = req0 ? 2'b01 : 2'b10;
`else
        // On a tie the input that did not own the previous frame wins
        if (req0 && req1) begin
            next_grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            next_grant = req0 ? 2'b01 : 2'b10;
        end
`endif
    end

    always_comb begin
        source_data  = '0;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        sink0_ready  = drop0;
        sink1_ready  = drop1;
        if (state == BUSY) begin
            if (grant[1]) begin
                source_data  = sink1_data;
                source_valid = sink1_valid;
                source_sop   = sink1_sop;
                source_eop   = sink1_eop;
                sink1_ready  = source_ready;
            end else begin
                source_data  = sink0_data;
                source_valid = sink0_valid;
                source_sop   = sink0_sop;
                source_eop   = sink0_eop;
                sink0_ready  = source_ready;
            end
        end
    end

    // A single-beat packet carries its own type, so the sop beat overrides the latched one
    assign accept        = source_valid & source_ready;
    assign eff_type      = source_sop ? source_data[3:0] : pkt_type;
    assign release_frame = accept & source_eop & (eff_type == 4'h0);
    assign frame_done    = release_frame;

    assign drop_inc = {1'b0, drop0} + {1'b0, drop1};
    assign drop_sum = {1'b0, drop_count} + {{(CNT_WIDTH-1){1'b0}}, drop_inc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= 2'b00;
            in_pkt      <= 1'b0;
            pkt_type    <= 4'h0;
            frame_count <= '0;
            drop_count  <= '0;
            proto_err   <= 1'b0;
`ifndef VIP_ARB_FIXED_PRIORITY_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
                    if (req0 || req1) begin
                        grant <= next_grant;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        if (source_sop) begin
                            pkt_type <= source_data[3:0];
                            in_pkt   <= 1'b1;
                            if (in_pkt) begin
                                proto_err <= 1'b1;
                            end
                        end
                        if (source_eop) begin
                            in_pkt <= 1'b0;
                        end
                    end
                    if (release_frame) begin
                        state       <= IDLE;
                        grant       <= 2'b00;
                        frame_count <= frame_count + 1'b1;
`ifndef VIP_ARB_FIXED_PRIORITY_EN
                        last_grant  <= grant[1];
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vip_frame_arbiter.sv
// Self-checking bench for vip_frame_arbiter: vector table, directed corner sequences and
// randomized frames checked against a frame-level arbitration model.
module tb_vip_frame_arbiter;

    localparam int BW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] sink0_data;
    logic          sink0_valid, sink0_sop, sink0_eop, sink0_ready;
    logic [BW-1:0] sink1_data;
    logic          sink1_valid, sink1_sop, sink1_eop, sink1_ready;
    logic [BW-1:0] source_data;
    logic          source_valid, source_sop, source_eop;
    logic          source_ready;
    logic [1:0]    grant;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;
    logic          proto_err;

    always #5 clk = ~clk;

    vip_frame_arbiter #(.BITWIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .sink0_data(sink0_data), .sink0_valid(sink0_valid), .sink0_sop(sink0_sop),
        .sink0_eop(sink0_eop), .sink0_ready(sink0_ready),
        .sink1_data(sink1_data), .sink1_valid(sink1_valid), .sink1_sop(sink1_sop),
        .sink1_eop(sink1_eop), .sink1_ready(sink1_ready),
        .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
        .source_eop(source_eop), .source_ready(source_ready),
        .grant(grant), .frame_done(frame_done), .frame_count(frame_count),
        .drop_count(drop_count), .proto_err(proto_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        ffirst;
        logic        flast;
        int          src;
    } beat_t;

    typedef struct {
        logic        v0, s0, e0;
        logic [31:0] d0;
        logic        v1, s1, e1;
        logic [31:0] d1;
        logic [1:0]  g;
        logic        sv;
        logic [31:0] sd;
        logic        r0, r1, fd;
    } vec_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t expq[$];
    vec_t  vecs[8];
    int    compared      = 0;
    int    mismatched    = 0;
    int    model_last    = 1;
    int    exp_frames    = 0;
    int    last_fd_cycle = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int v0, input int s0, input int e0, input logic [31:0] d0,
                                 input int v1, input int s1, input int e1, input logic [31:0] d1,
                                 input int rdy);
        sink0_valid  = 1'(v0);
        sink0_sop    = 1'(s0);
        sink0_eop    = 1'(e0);
        sink0_data   = d0;
        sink1_valid  = 1'(v1);
        sink1_sop    = 1'(s1);
        sink1_eop    = 1'(e1);
        sink1_data   = d1;
        source_ready = 1'(rdy);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkvec(input int v0, input int s0, input int e0, input int d0,
                                   input int v1, input int s1, input int e1, input int d1,
                                   input int g, input int sv, input int sd,
                                   input int r0, input int r1, input int fd);
        vec_t v;
        v.v0 = 1'(v0); v.s0 = 1'(s0); v.e0 = 1'(e0); v.d0 = 32'(d0);
        v.v1 = 1'(v1); v.s1 = 1'(s1); v.e1 = 1'(e1); v.d1 = 32'(d1);
        v.g  = 2'(g);  v.sv = 1'(sv); v.sd = 32'(sd);
        v.r0 = 1'(r0); v.r1 = 1'(r1); v.fd = 1'(fd);
        return v;
    endfunction

    // A frame is nctrl control packets of clen beats followed by one video packet of vlen beats
    task automatic addFrame(input int src, input int nctrl, input int clen, input int vlen,
                            input logic [3:0] ctyp);
        beat_t b;
        int    len;
        for (int p = 0; p <= nctrl; p++) begin
            len = (p == nctrl) ? vlen : clen;
            for (int k = 0; k < len; k++) begin
                b.data = $urandom;
                if (k == 0) b.data[3:0] = (p == nctrl) ? 4'h0 : ctyp;
                b.sop    = (k == 0);
                b.eop    = (k == len - 1);
                b.ffirst = (p == 0) && (k == 0);
                b.flast  = (p == nctrl) && (k == len - 1);
                b.src    = src;
                if (src == 0) q0.push_back(b);
                else          q1.push_back(b);
            end
        end
    endtask

    // Both inputs always present their next frame, so whole frames alternate (or input 0 goes first)
    task automatic buildExpected();
        int    i0 = 0;
        int    i1 = 0;
        int    pick;
        int    last;
        beat_t b;
        last = model_last;
        while (i0 < q0.size() || i1 < q1.size()) begin
`ifdef VIP_ARB_FIXED_PRIORITY_EN
            pick = (i0 < q0.size()) ? 0 : 1;
`else
            if (i0 < q0.size() && i1 < q1.size()) pick = (last == 0) ? 1 : 0;
            else                                  pick = (i0 < q0.size()) ? 0 : 1;
`endif
            do begin
                if (pick == 0) begin b = q0[i0]; i0++; end
                else           begin b = q1[i1]; i1++; end
                expq.push_back(b);
            end while (!b.flast);
            last = pick;
            exp_frames++;
        end
        model_last = last;
    endtask

    task automatic driveFromQueues(input int mode, input int cyc);
        case (mode)
            0:       source_ready = 1'b1;
            1:       source_ready = ((cyc % 2) == 1);
            default: source_ready = ($urandom_range(3, 0) != 0);
        endcase
        if (q0.size() > 0) begin
            sink0_valid = q0[0].ffirst || (mode != 2) || ($urandom_range(3, 0) != 0);
            sink0_data  = q0[0].data;
            sink0_sop   = q0[0].sop;
            sink0_eop   = q0[0].eop;
        end else begin
            sink0_valid = 1'b0; sink0_sop = 1'b0; sink0_eop = 1'b0; sink0_data = '0;
        end
        if (q1.size() > 0) begin
            sink1_valid = q1[0].ffirst || (mode != 2) || ($urandom_range(3, 0) != 0);
            sink1_data  = q1[0].data;
            sink1_sop   = q1[0].sop;
            sink1_eop   = q1[0].eop;
        end else begin
            sink1_valid = 1'b0; sink1_sop = 1'b0; sink1_eop = 1'b0; sink1_data = '0;
        end
    endtask

    task automatic runFrames(input int mode, input int budget);
        int    cyc = 0;
        logic  acc0, acc1;
        beat_t e;
        buildExpected();
        while (expq.size() > 0 && cyc < budget) begin
            driveFromQueues(mode, cyc);
            @(negedge clk);
            if (source_valid) begin
                e = expq[0];
                checkOutput("grant_owner", 32'(grant), (e.src == 0) ? 32'd1 : 32'd2);
                checkOutput("ready_granted", (e.src == 0) ? sink0_ready : sink1_ready, source_ready);
                checkOutput("ready_other", (e.src == 0) ? sink1_ready : sink0_ready, 0);
                if (source_ready) begin
                    checkOutput("beat_data", source_data, e.data);
                    checkOutput("beat_sop_eop", {source_sop, source_eop}, {e.sop, e.eop});
                    checkOutput("frame_done_beat", frame_done, e.flast);
                    if (e.flast) last_fd_cycle = cyc;
                    void'(expq.pop_front());
                end else begin
                    checkOutput("frame_done_stall", frame_done, 0);
                end
            end else begin
                checkOutput("frame_done_idle", frame_done, 0);
            end
            acc0 = sink0_valid & sink0_ready;
            acc1 = sink1_valid & sink1_ready;
            nextCycle();
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            cyc++;
        end
        if (expq.size() != 0) begin
            checkOutput("frames_timeout_beats_left", expq.size(), 0);
            expq.delete();
            q0.delete();
            q1.delete();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("frame_count", 32'(frame_count), exp_frames % 256);
        nextCycle();
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_grant", 32'(grant), 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_frame_count", 32'(frame_count), 0);
        checkOutput("reset_drop_count", 32'(drop_count), 0);
        checkOutput("reset_proto_err", proto_err, 0);
        checkOutput("reset_source_valid", source_valid, 0);
        nextCycle();
        rst = 1'b1;

        // Simultaneous requests straight after reset, then a re-request from input 0
        vecs[0] = mkvec(1,1,0,'h100, 1,1,1,'h200, 0,0,0,     0,0,0);
        vecs[1] = mkvec(1,1,0,'h100, 1,1,1,'h200, 1,1,'h100, 1,0,0);
        vecs[2] = mkvec(1,0,1,'h101, 1,1,1,'h200, 1,1,'h101, 1,0,1);
        vecs[3] = mkvec(1,1,1,'h300, 1,1,1,'h200, 0,0,0,     0,0,0);
`ifdef VIP_ARB_FIXED_PRIORITY_EN
        vecs[4] = mkvec(1,1,1,'h300, 1,1,1,'h200, 1,1,'h300, 1,0,1);
        vecs[5] = mkvec(0,0,0,0,     1,1,1,'h200, 0,0,0,     0,0,0);
        vecs[6] = mkvec(0,0,0,0,     1,1,1,'h200, 2,1,'h200, 0,1,1);
`else
        vecs[4] = mkvec(1,1,1,'h300, 1,1,1,'h200, 2,1,'h200, 0,1,1);
        vecs[5] = mkvec(1,1,1,'h300, 0,0,0,0,     0,0,0,     0,0,0);
        vecs[6] = mkvec(1,1,1,'h300, 0,0,0,0,     1,1,'h300, 1,0,1);
`endif
        vecs[7] = mkvec(0,0,0,0,     0,0,0,0,     0,0,0,     0,0,0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].v0, vecs[i].s0, vecs[i].e0, vecs[i].d0,
                          vecs[i].v1, vecs[i].s1, vecs[i].e1, vecs[i].d1, 1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].g));
            checkOutput($sformatf("vec%0d_valid", i), source_valid, vecs[i].sv);
            checkOutput($sformatf("vec%0d_data", i), source_data, vecs[i].sd);
            checkOutput($sformatf("vec%0d_ready0", i), sink0_ready, vecs[i].r0);
            checkOutput($sformatf("vec%0d_ready1", i), sink1_ready, vecs[i].r1);
            checkOutput($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].fd);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("table_frame_count", 32'(frame_count), 3);
        nextCycle();

        // Sop inside a packet: sticky error, type relatched so the following eop does not release
        applyStimulus(1,1,0,32'h10, 0,0,0,0, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("proto_grant", 32'(grant), 1);
        nextCycle();
        applyStimulus(1,1,0,32'h2F, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("proto_err_before", proto_err, 0);
        nextCycle();
        applyStimulus(1,0,1,32'h55, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("proto_err_set", proto_err, 1);
        checkOutput("proto_ctrl_eop_no_done", frame_done, 0);
        nextCycle();
        applyStimulus(1,1,1,32'h60, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("proto_grant_held", 32'(grant), 1);
        checkOutput("proto_video_done", frame_done, 1);
        nextCycle();
        applyStimulus(0,0,0,0, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("proto_err_sticky", proto_err, 1);
        checkOutput("proto_grant_released", 32'(grant), 0);
        checkOutput("proto_frame_count", 32'(frame_count), 4);
        nextCycle();

        // Orphan beats while idle, including double drops and saturation
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0,0,0,0, 1,0,0,32'(i), 1);
            @(negedge clk);
            checkOutput("orphan_ready1", sink1_ready, 1);
            checkOutput("orphan_no_source", source_valid, 0);
            checkOutput("orphan_grant", 32'(grant), 0);
            nextCycle();
        end
        applyStimulus(0,0,0,0, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("drop_count_3", 32'(drop_count), 3);
        nextCycle();
        applyStimulus(1,0,0,32'h7, 1,0,0,32'h8, 1);
        @(negedge clk);
        checkOutput("orphan_both_ready", {sink0_ready, sink1_ready}, 2'b11);
        nextCycle();
        applyStimulus(0,0,0,0, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("drop_count_double", 32'(drop_count), 5);
        nextCycle();
        applyStimulus(0,0,0,0, 1,0,0,32'h9, 1);
        repeat (249) nextCycle();
        applyStimulus(0,0,0,0, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("drop_count_254", 32'(drop_count), 254);
        nextCycle();
        applyStimulus(1,0,0,32'h7, 1,0,0,32'h8, 1);
        nextCycle();
        applyStimulus(0,0,0,0, 1,0,0,32'h9, 1);
        repeat (50) nextCycle();
        applyStimulus(0,0,0,0, 0,0,0,0, 1);
        @(negedge clk);
        checkOutput("drop_count_saturated", 32'(drop_count), 255);
        nextCycle();

        // Asynchronous reset in the middle of a video packet
        applyStimulus(1,1,0,32'h0000_0A00, 0,0,0,0, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("busy_grant_before_reset", 32'(grant), 1);
        checkOutput("busy_valid_before_reset", source_valid, 1);
        nextCycle();
        applyStimulus(1,0,0,32'h1234_5670, 0,0,0,0, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_grant", 32'(grant), 0);
        checkOutput("async_reset_valid", source_valid, 0);
        checkOutput("async_reset_frame_count", 32'(frame_count), 0);
        checkOutput("async_reset_drop_count", 32'(drop_count), 0);
        checkOutput("async_reset_proto_err", proto_err, 0);
        checkOutput("async_reset_frame_done", frame_done, 0);
        nextCycle();
        applyStimulus(0,0,0,0, 0,0,0,0, 1);
        nextCycle();
        rst        = 1'b1;
        model_last = 1;
        exp_frames = 0;

        // Control packet then video packet on input 0 alone
        addFrame(0, 1, 4, 8, 4'hF);
        runFrames(0, 64);

        // Both inputs hold multi-packet frames: frames must never interleave
        addFrame(0, 2, 2, 3, 4'hF);
        addFrame(1, 1, 2, 2, 4'hF);
        runFrames(0, 64);

        // Alternating backpressure over an 8-beat video packet
        addFrame(0, 0, 0, 8, 4'hF);
        last_fd_cycle = -1;
        runFrames(1, 64);
        checkOutput("backpressure_done_cycle", 32'(last_fd_cycle), 15);

        for (int r = 0; r < 20; r++) begin
            int n0;
            int n1;
            n0 = $urandom_range(3, 0);
            n1 = $urandom_range(3, (n0 == 0) ? 1 : 0);
            for (int f = 0; f < n0; f++)
                addFrame(0, $urandom_range(2, 0), $urandom_range(3, 1), $urandom_range(5, 1),
                         4'($urandom_range(15, 1)));
            for (int f = 0; f < n1; f++)
                addFrame(1, $urandom_range(2, 0), $urandom_range(3, 1), $urandom_range(5, 1),
                         4'($urandom_range(15, 1)));
            runFrames(2, 3000);
        end

        @(negedge clk);
        checkOutput("final_drop_count", 32'(drop_count), 0);
        checkOutput("final_proto_err", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
